// File: rtl/rv_pkg.sv
// Shared RV32 definitions: datapath width, M-extension funct3 codes, mul/div FSM states.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: multiply add-shift-right or
// restoring divide shift-left-compare-subtract.
module muldiv_step #(
    parameter int unsigned W = 32
) (
    input  logic         is_div_i,
    input  logic [W:0]   hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0] sum;
    logic [W:0] rem_sh;
    logic [W:0] diff;
    logic       ge;

    always_comb begin
        sum    = hi_i + (lo_i[0] ? {1'b0, b_i} : '0);
        rem_sh = {hi_i[W-1:0], lo_i[W-1]};
        diff   = rem_sh - {1'b0, b_i};
        ge     = (rem_sh >= {1'b0, b_i});
        hi_o   = '0;
        lo_o   = '0;
        if (is_div_i) begin
            hi_o = ge ? diff : rem_sh;
            lo_o = {lo_i[W-2:0], ge};
        end else begin
            // Carry out of the add lands in the top of hi after the shift.
            hi_o = {1'b0, sum[W:1]};
            lo_o = {sum[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage: one bit per cycle over
// operand magnitudes, sign fix applied when the result is written.
module ex_muldiv
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;

    logic [XLEN:0]    step_hi;
    logic [XLEN-1:0]  step_lo;

    muldiv_step #(.W(XLEN)) u_step (
        .is_div_i (f3_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Operand conditioning and special-case detection at acceptance.
    logic            sgn_a, sgn_b, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        sgn_a    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        sgn_b    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa       = sgn_a & alu_a[XLEN-1];
        sb       = sgn_b & alu_b[XLEN-1];
        a_mag    = sa ? (~alu_a + XLEN'(1)) : alu_a;
        b_mag    = sb ? (~alu_b + XLEN'(1)) : alu_b;
        div_zero = funct3[2] && (alu_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (alu_a == INT_MIN) && (alu_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            spec_res = funct3[1] ? alu_a : '1;
        end else begin
            spec_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    // Final result from the last step's outputs, with sign fix.
    logic [PW-1:0]   prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fin_res;

    always_comb begin
        prod     = {step_hi[XLEN-1:0], step_lo};
        prod_fix = neg_q_q ? (~prod + PW'(1)) : prod;
        quo_fix  = neg_q_q ? (~step_lo + XLEN'(1)) : step_lo;
        rem_fix  = neg_r_q ? (~step_hi[XLEN-1:0] + XLEN'(1)) : step_hi[XLEN-1:0];
        case (f3_q)
            F3_MUL:                          fin_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:    fin_res = prod_fix[PW-1:XLEN];
            F3_DIV, F3_DIVU:                 fin_res = quo_fix;
            default:                         fin_res = rem_fix;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        f3_d     = f3_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;

        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    f3_d    = funct3;
                    neg_q_d = sa ^ sb;
                    neg_r_d = sa;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    b_d     = b_mag;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (special) begin
                        state_d  = MD_DONE;
                        done_d   = 1'b1;
                        result_d = spec_res;
                    end else begin
                        state_d  = MD_RUN;
                    end
                end
            end
            MD_RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = MD_DONE;
                    done_d   = 1'b1;
                    result_d = fin_res;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A redirect kills the op without touching the visible result.
        if (flush) begin
            state_d  = MD_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table through a result/latency scoreboard,
// plus hand sequences for ignored start, flush and mid-op reset.
module tb_ex_muldiv;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the
    // first idle cycle after DONE so the next op tests earliest acceptance.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit poke);
        bit seen;
        funct3 = f3; alu_a = a; alu_b = b; start = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        alu_a  = $urandom;
        alu_b  = $urandom;
        seen   = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) check({name, " busy@t+1"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
                check({name, " result"}, result, exp_q.pop_front());
                check({name, " latency"}, 32'(k), 32'(lat_q.pop_front()));
                check({name, " busy@done"}, 32'(busy), 32'd1);
                last_res = exp;
            end else begin
                start = poke && (k >= 5) && (k < 8);
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: no done within 40 cycles, expected at t+%0d", name, lat);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        @(negedge clk);
        check({name, " busy after done"}, 32'({busy, done}), 32'd0);
    endtask

    // Idle watch: no done, not busy and result held for n cycles.
    task automatic watch_idle(input string name, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy || done || (result !== last_res)) bad++;
        end
        check({name, " idle cycles with activity"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; alu_a = '0; alu_b = '0;

        add_vec("MUL 7*-3",        F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        add_vec("MULH min*min",    F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33);
        add_vec("MULHU -1*-1",     F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add_vec("MULHSU -1*max",   F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        add_vec("MULH -2*3",       F3_MULH,   32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF, 33);
        add_vec("MULH -1*-1",      F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33);
        add_vec("MULHU min*2",     F3_MULHU,  32'h80000000,   32'd2,        32'h00000001, 33);
        add_vec("DIV -7/2",        F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
        add_vec("REM -7/2",        F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
        add_vec("DIV 7/-2",        F3_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        add_vec("REM 7/-2",        F3_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001, 33);
        add_vec("DIVU 100/7",      F3_DIVU,   32'd100,        32'd7,        32'd14,       33);
        add_vec("REMU 100/7",      F3_REMU,   32'd100,        32'd7,        32'd2,        33);
        add_vec("DIVU max/1",      F3_DIVU,   32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 33);
        add_vec("DIV 0/5",         F3_DIV,    32'd0,          32'd5,        32'd0,        33);
        add_vec("DIVU 5/0",        F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1);
        add_vec("REM 5/0",         F3_REM,    32'd5,          32'd0,        32'd5,        1);
        add_vec("REMU -9/0",       F3_REMU,   32'hFFFFFFF7,   32'd0,        32'hFFFFFFF7, 1);
        add_vec("DIV min/-1",      F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
        add_vec("REM min/-1",      F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1);

        repeat (3) @(negedge clk);
        check("reset busy",   32'(busy), 32'd0);
        check("reset done",   32'(done), 32'd0);
        check("reset result", result,    32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

        // start pulsed mid-RUN must be ignored
        run_op("DIVU 100/7 poked", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        watch_idle("after poke", 40);

        // flush and start together in IDLE: nothing accepted
        funct3 = F3_MUL; alu_a = 32'd2; alu_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        watch_idle("flush+start", 40);

        // flush at t+10 of a DIV
        funct3 = F3_DIV; alu_a = 32'hFFFFFFF9; alu_b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            flush = (k == 10);
            if (k == 9) check("DIV pre-flush busy", 32'(busy), 32'd1);
        end
        check("flush busy",   32'(busy), 32'd0);
        check("flush done",   32'(done), 32'd0);
        check("flush result", result,    last_res);
        flush = 1'b0;
        watch_idle("after flush", 40);

        // synchronous reset at t+5 of a MUL
        run_op("MUL 6*7", F3_MUL, 32'd6, 32'd7, 32'd42, 33, 1'b0);
        funct3 = F3_MUL; alu_a = 32'd7; alu_b = 32'hFFFFFFFD; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rst = (k == 5);
        end
        check("midop rst busy",   32'(busy), 32'd0);
        check("midop rst done",   32'(done), 32'd0);
        check("midop rst result", result,    32'd0);
        rst = 1'b0;
        last_res = 32'd0;
        watch_idle("after rst", 40);
        run_op("REMU 100/7 post-rst", F3_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
